// File: rtl/sync_xfer_pkg.sv
// Shared types, default sizes and the rotating-priority search for the sync transfer scheduler.
// Latency: combinational helpers only.
// Backpressure: none; pure definitions.
package sync_xfer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int N_DEF          = 12;
   localparam int R_DEF          = 4;
   localparam int HOLD_TICKS_DEF = 2;
   localparam int TIMEOUT_DEF    = 1024;
   localparam int R_MAX          = 16;

   // One-hot winner: first set bit of req searching upward from ptr+1, wrapping at r.
   function automatic logic [R_MAX-1:0] next_grant(input logic [R_MAX-1:0] req,
                                                    input logic [3:0]       ptr,
                                                    input int               r);
      logic [R_MAX-1:0] oh;
      logic [4:0]       cand;
      oh = '0;
      for (int k = 1; k <= R_MAX; k++) begin
         cand = {1'b0, ptr} + 5'(k);
         if (cand >= 5'(r)) cand = cand - 5'(r);
         if (k <= r && oh == '0 && req[cand[3:0]]) oh[cand[3:0]] = 1'b1;
      end
      return oh;
   endfunction

endpackage

// File: rtl/sync_xfer_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the requester after ptr, wrapping modulo R.
// Latency: purely combinational, grant valid in the same cycle as req.
// Backpressure: en low suppresses the grant; the pointer is owned by the caller.
module rr_arbiter
   import sync_xfer_pkg::*;
#(
   parameter int R = 4
) (
   input  logic [R-1:0]         req,
   input  logic [$clog2(R)-1:0] ptr,
   input  logic                 en,
   output logic                 grant_valid,
   output logic [$clog2(R)-1:0] grant_idx
);

   localparam int PW = $clog2(R);

   logic [R_MAX-1:0] pick_oh;

   // Rotate-search the requests, then encode the single winning bit.
   always_comb begin
      pick_oh     = next_grant(R_MAX'(req), 4'(ptr), R);
      grant_valid = en & (|pick_oh);
      grant_idx   = '0;
      for (int i = 0; i < R; i++) begin
         if (pick_oh[i]) grant_idx = PW'(i);
      end
   end

endmodule

// File: rtl/sync_xfer_scheduler.sv
// Shares one fast-to-slow synchronizer among R requesters, holding each word for HOLD_TICKS slow ticks.
// Latency: word on sync_d one cycle after grant; ack one cycle after the HOLD_TICKS-th counted tick.
// Backpressure: requesters wait on level req until their one-cycle ack; a stalled slow side trips the watchdog.
module sync_xfer_scheduler
   import sync_xfer_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int R          = R_DEF,
   parameter int HOLD_TICKS = HOLD_TICKS_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                 fast_clk,
   input  logic                 reset,
   input  logic [R-1:0]         req,
   input  logic [R*N-1:0]       data_in,
   input  logic                 slow_tick,
   output logic [N-1:0]         sync_d,
   output logic [$clog2(R)-1:0] sync_tag,
   output logic [R-1:0]         ack,
   output logic                 busy,
   output logic                 err_timeout
);

   localparam int PW = $clog2(R);
   localparam int TW = $clog2(HOLD_TICKS + 1);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TICK_ARM = TW'(HOLD_TICKS - 1);
   localparam logic [WW-1:0] WD_ARM   = WW'(TIMEOUT - 2);
   localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT - 1);

   state_t         state_q, state_d;
   logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
   logic [WW-1:0]  wd_cnt_q, wd_cnt_d;
   logic [PW-1:0]  ptr_q, ptr_d;
   logic [N-1:0]   sync_d_nxt;
   logic [PW-1:0]  sync_tag_nxt;
   logic           err_nxt;
   logic           grant_valid;
   logic [PW-1:0]  grant_idx;
   logic [N-1:0]   words [R];

   rr_arbiter #(.R(R)) u_arb (
      .req         (req),
      .ptr         (ptr_q),
      .en          (state_q == IDLE),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Split the flat data bus into per-requester words for the grant mux.
   always_comb begin
      for (int i = 0; i < R; i++) words[i] = data_in[i*N +: N];
   end

   // Next-state logic: grant in IDLE, count ticks / watchdog in HOLD, release pointer in ACK.
   always_comb begin
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      wd_cnt_d     = wd_cnt_q;
      ptr_d        = ptr_q;
      sync_d_nxt   = sync_d;
      sync_tag_nxt = sync_tag;
      err_nxt      = err_timeout;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d      = HOLD;
               sync_d_nxt   = words[grant_idx];
               sync_tag_nxt = grant_idx;
               tick_cnt_d   = '0;
               wd_cnt_d     = '0;
            end
         end
         HOLD: begin
            if (slow_tick) begin
               tick_cnt_d = tick_cnt_q + 1'b1;
               wd_cnt_d   = '0;
               if (tick_cnt_q == TICK_ARM) state_d = ACK;
            end else begin
               if (wd_cnt_q != WD_MAX) wd_cnt_d = wd_cnt_q + 1'b1;
               // Slow side went quiet: finish the transfer but flag it.
               if (wd_cnt_q >= WD_ARM) begin
                  err_nxt = 1'b1;
                  state_d = ACK;
               end
            end
         end
         ACK: begin
            ptr_d   = sync_tag;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and output registers; reset aborts any transfer in flight.
   always_ff @(posedge fast_clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         tick_cnt_q  <= '0;
         wd_cnt_q    <= '0;
         ptr_q       <= PW'(R - 1);
         sync_d      <= '0;
         sync_tag    <= '0;
         err_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         wd_cnt_q    <= wd_cnt_d;
         ptr_q       <= ptr_d;
         sync_d      <= sync_d_nxt;
         sync_tag    <= sync_tag_nxt;
         err_timeout <= err_nxt;
      end
   end

   // Status decode straight off the state register.
   always_comb begin
      ack  = '0;
      busy = (state_q != IDLE);
      if (state_q == ACK) ack = R'(1) << sync_tag;
   end

endmodule
